// File: rtl/stack_sequencer.sv
// Program sequencer for the stack CPU: plays a stored program onto the CPU nibble
// port, one opcode in the fetch cycle followed by its operand for every execute cycle.
module stack_sequencer #(
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 prog_we,
   input  logic [ADDR_BITS-1:0] prog_addr,
   input  logic [7:0]           prog_data,
   input  logic [ADDR_BITS-1:0] prog_len,
   input  logic                 start,
   output logic                 cpu_rst,
   output logic [3:0]           cpu_inbits,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRST,
      S_FETCH,
      S_EXEC,
      S_DONE
   } state_t;

   state_t               state_q;
   logic                 cpu_rst_q;
   logic [3:0]           inbits_q;
   logic                 busy_q;
   logic                 done_q;
   logic [ADDR_BITS-1:0] pc_q;
   logic [ADDR_BITS-1:0] last_q;
   logic [1:0]           cnt_q;
   logic [7:0]           mem_q [2**ADDR_BITS];

   logic [7:0]           cur_word;
   logic [ADDR_BITS-1:0] pc_inc;
   logic [3:0]           nxt_op;

   // Execute cycles after the fetch cycle, minus one, for each opcode.
   function automatic logic [1:0] exec_cnt(input logic [3:0] op);
      case (op)
         4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_cnt = 2'd1;
         4'h9, 4'ha, 4'hc, 4'hd:             exec_cnt = 2'd2;
         default:                            exec_cnt = 2'd0;
      endcase
   endfunction

   assign cur_word = mem_q[pc_q];
   assign pc_inc   = pc_q + 1'b1;
   assign nxt_op   = mem_q[pc_inc][3:0];

   // The store is frozen while a run is in progress.
   always_ff @(posedge clk) begin
      if (prog_we && !busy_q) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cpu_rst_q <= 1'b0;
         inbits_q  <= 4'h0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pc_q      <= '0;
         last_q    <= '0;
         cnt_q     <= 2'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cpu_rst_q <= 1'b0;
               inbits_q  <= 4'h0;
               if (start) begin
                  state_q   <= S_CRST;
                  cpu_rst_q <= 1'b1;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  pc_q      <= '0;
                  last_q    <= prog_len;
               end
            end
            S_CRST: begin
               cpu_rst_q <= 1'b0;
               inbits_q  <= cur_word[3:0];
               state_q   <= S_FETCH;
            end
            S_FETCH: begin
               cnt_q    <= exec_cnt(cur_word[3:0]);
               inbits_q <= cur_word[7:4];
               state_q  <= S_EXEC;
            end
            S_EXEC: begin
               if (cnt_q != 2'd0) begin
                  cnt_q <= cnt_q - 2'd1;
               end else if (pc_q == last_q) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  inbits_q <= 4'h0;
               end else begin
                  // Next opcode must be on the port in the CPU's fetch cycle.
                  pc_q     <= pc_inc;
                  inbits_q <= nxt_op;
                  state_q  <= S_FETCH;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cpu_rst    = cpu_rst_q;
   assign cpu_inbits = inbits_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: plays small programs and compares the nibble
// stream and control outputs cycle by cycle against hand-written sequences.
module tb_stack_sequencer;

   logic       clk;
   logic       rst;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [3:0] prog_len;
   logic       start;
   logic       cpu_rst;
   logic [3:0] cpu_inbits;
   logic       busy;
   logic       done;
   logic [3:0] pc;

   int vectors;
   int miscompares;
   logic [3:0] seq [$];

   stack_sequencer #(.ADDR_BITS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_len   (prog_len),
      .start      (start),
      .cpu_rst    (cpu_rst),
      .cpu_inbits (cpu_inbits),
      .busy       (busy),
      .done       (done),
      .pc         (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   // Start a run and compare every cycle against seq; optionally disturb mid-run.
   task automatic run(input string tag, input logic [3:0] len, input bit disturb,
                      input logic [3:0] last_pc);
      prog_len = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      check({tag, " crst"}, {7'd0, cpu_rst}, 8'd1);
      check({tag, " busy0"}, {7'd0, busy}, 8'd1);
      check({tag, " done0"}, {7'd0, done}, 8'd0);
      check({tag, " inb0"}, {4'd0, cpu_inbits}, 8'd0);
      for (int k = 0; k < seq.size(); k++) begin
         tick();
         if (disturb && k == 2) begin
            prog_we   = 1'b1;
            prog_addr = 4'd0;
            prog_data = 8'hff;
            prog_len  = 4'd0;
            start     = 1'b1;
         end
         if (disturb && k == 4) begin
            prog_we  = 1'b0;
            start    = 1'b0;
         end
         check($sformatf("%s inbits[%0d]", tag, k), {4'd0, cpu_inbits}, {4'd0, seq[k]});
         check($sformatf("%s busy[%0d]", tag, k), {7'd0, busy}, 8'd1);
         check($sformatf("%s cpurst[%0d]", tag, k), {7'd0, cpu_rst}, 8'd0);
      end
      tick();
      check({tag, " end busy"}, {7'd0, busy}, 8'd0);
      check({tag, " end done"}, {7'd0, done}, 8'd1);
      check({tag, " end inbits"}, {4'd0, cpu_inbits}, 8'd0);
      check({tag, " end pc"}, {4'd0, pc}, {4'd0, last_pc});
      tick();
      check({tag, " idle done"}, {7'd0, done}, 8'd1);
      check({tag, " idle busy"}, {7'd0, busy}, 8'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      prog_we     = 1'b0;
      prog_addr   = 4'd0;
      prog_data   = 8'd0;
      prog_len    = 4'd0;
      start       = 1'b0;
      rst         = 1'b1;
      #3;
      check("rst cpu_rst", {7'd0, cpu_rst}, 8'd0);
      check("rst inbits", {4'd0, cpu_inbits}, 8'd0);
      check("rst busy", {7'd0, busy}, 8'd0);
      check("rst done", {7'd0, done}, 8'd0);
      check("rst pc", {4'd0, pc}, 8'd0);
      tick();
      rst = 1'b0;
      tick();

      // PUSH 3, PUSH 5, BINA add, OUTL
      load(4'd0, 8'h31);
      load(4'd1, 8'h51);
      load(4'd2, 8'h08);
      load(4'd3, 8'h03);
      seq = '{4'h1, 4'h3, 4'h3, 4'h1, 4'h5, 4'h5, 4'h8, 4'h0, 4'h0, 4'h3, 4'h0};
      run("add", 4'd3, 1'b0, 4'd3);

      // PUSH 7, PUSH 6, MULT
      load(4'd0, 8'h71);
      load(4'd1, 8'h61);
      load(4'd2, 8'h09);
      seq = '{4'h1, 4'h7, 4'h7, 4'h1, 4'h6, 4'h6, 4'h9, 4'h0, 4'h0, 4'h0};
      run("mult", 4'd2, 1'b0, 4'd2);

      // Async reset while MULT is executing
      prog_len = 4'd2;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      repeat (8) tick();
      check("pre-abort pc", {4'd0, pc}, 8'd2);
      check("pre-abort busy", {7'd0, busy}, 8'd1);
      #1;
      rst = 1'b1;
      #1;
      check("abort busy", {7'd0, busy}, 8'd0);
      check("abort pc", {4'd0, pc}, 8'd0);
      check("abort done", {7'd0, done}, 8'd0);
      check("abort cpu_rst", {7'd0, cpu_rst}, 8'd0);
      check("abort inbits", {4'd0, cpu_inbits}, 8'd0);
      rst = 1'b0;
      tick();
      check("post-abort busy", {7'd0, busy}, 8'd0);
      run("mult replay", 4'd2, 1'b0, 4'd2);

      // PUSH 4, PUSH 0, IDIV, PUSF; writes and start mid-run must be ignored
      load(4'd0, 8'h41);
      load(4'd1, 8'h01);
      load(4'd2, 8'h0a);
      load(4'd3, 8'h26);
      seq = '{4'h1, 4'h4, 4'h4, 4'h1, 4'h0, 4'h0, 4'ha, 4'h0, 4'h0, 4'h0,
              4'h6, 4'h2, 4'h2};
      run("idiv disturbed", 4'd3, 1'b1, 4'd3);
      run("idiv replay", 4'd3, 1'b0, 4'd3);

      // Full store of NOOPs: 1 + 16*2 busy cycles
      for (int a = 0; a < 16; a++) load(4'(a), 8'h00);
      seq.delete();
      for (int k = 0; k < 32; k++) seq.push_back(4'h0);
      run("full store", 4'd15, 1'b0, 4'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
